rv32_fetch: RTL and testbench



---
 rtl/rv32_fetch_pkg.sv | 17 +
 rtl/rv32_fetch.sv | 136 +++++++++++++
 tb/tb_rv32_fetch.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the rv32 instruction fetch stage.
//   - fetch_state_e        : fetch controller states
//   - RV32_FETCH_RESET_PC  : default fetch address after reset
//   - RV32_INSTR_WIDTH     : instruction / address word width
package rv32_fetch_pkg;

  localparam int          RV32_INSTR_WIDTH    = 32;
  localparam logic [31:0] RV32_FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rv32_fetch.sv
// rv32 instruction fetch stage.
// Owns the fetch PC and keeps at most one word request outstanding to
// instruction memory. Each returned word is presented with its PC to decode
// through registered outputs. A one-entry skid buffer absorbs a response that
// arrives while decode is stalled. A branch redirect from execute overrides
// everything else.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall_in               decode cannot accept; outputs hold
//   branch_in/branch_pc_in redirect request and target (low two bits ignored)
//   imem_req_valid_out     request valid (decoded from state only)
//   imem_req_ready_in      memory accepts the request
//   imem_addr_out          request address (fetch PC)
//   imem_resp_valid_in     response valid (no backpressure)
//   imem_resp_data_in      returned instruction word
//   valid_out/pc_out/instr_out  instruction presented to decode
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32_FETCH_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_in,
  input  logic                        branch_in,
  input  logic [RV32_INSTR_WIDTH-1:0] branch_pc_in,
  output logic                        imem_req_valid_out,
  input  logic                        imem_req_ready_in,
  output logic [RV32_INSTR_WIDTH-1:0] imem_addr_out,
  input  logic                        imem_resp_valid_in,
  input  logic [RV32_INSTR_WIDTH-1:0] imem_resp_data_in,
  output logic                        valid_out,
  output logic [RV32_INSTR_WIDTH-1:0] pc_out,
  output logic [RV32_INSTR_WIDTH-1:0] instr_out
);

  fetch_state_e                state_q, state_d;
  logic [RV32_INSTR_WIDTH-1:0] fetch_pc_q;
  logic [RV32_INSTR_WIDTH-1:0] req_pc_q;
  logic                        kill_q;
  logic [RV32_INSTR_WIDTH-1:0] buf_pc_q;
  logic [RV32_INSTR_WIDTH-1:0] buf_instr_q;

  logic req_fire;
  logic resp_fire;
  logic slot_free;
  logic load_resp;
  logic load_buf;
  logic capture;

  assign req_fire  = (state_q == REQ) && imem_req_ready_in;
  assign resp_fire = (state_q == WAIT) && imem_resp_valid_in;
  // The output slot can take a new word if it is empty or being consumed now.
  assign slot_free = !valid_out || !stall_in;
  assign load_resp = resp_fire && !kill_q && slot_free && !branch_in;
  assign load_buf  = (state_q == HOLD) && !stall_in && !branch_in;
  assign capture   = resp_fire && !kill_q && !slot_free && !branch_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_req_ready_in) state_d = WAIT;
      WAIT: begin
        if (imem_resp_valid_in) begin
          if (kill_q || slot_free || branch_in) state_d = REQ;
          else                                  state_d = HOLD;
        end
      end
      HOLD: if (!stall_in || branch_in) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: request side depends on registered state only
  always_comb begin
    imem_req_valid_out = (state_q == REQ);
    imem_addr_out      = fetch_pc_q;
  end

  // Fetch PC, kill flag and decode-facing output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      valid_out  <= 1'b0;
      pc_out     <= '0;
      instr_out  <= '0;
    end else begin
      if (branch_in)     fetch_pc_q <= {branch_pc_in[RV32_INSTR_WIDTH-1:2], 2'b00};
      else if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;

      // A redirect while a request is (or is becoming) outstanding must drop
      // the stale response; if that response lands in the same cycle it is
      // already being dropped, so nothing is left to kill.
      if (branch_in) begin
        if (req_fire)              kill_q <= 1'b1;
        else if (state_q == WAIT)  kill_q <= !imem_resp_valid_in;
      end else if (resp_fire) begin
        kill_q <= 1'b0;
      end

      if (branch_in) begin
        valid_out <= 1'b0;
      end else if (load_resp) begin
        valid_out <= 1'b1;
        pc_out    <= req_pc_q;
        instr_out <= imem_resp_data_in;
      end else if (load_buf) begin
        valid_out <= 1'b1;
        pc_out    <= buf_pc_q;
        instr_out <= buf_instr_q;
      end else if (!stall_in) begin
        valid_out <= 1'b0;
      end
    end
  end

  // In-flight PC and skid buffer: pure data, meaningful only under control state
  always_ff @(posedge clk) begin
    if (req_fire) req_pc_q <= fetch_pc_q;
    if (capture) begin
      buf_pc_q    <= req_pc_q;
      buf_instr_q <= imem_resp_data_in;
    end
  end

endmodule

// File: tb/tb_rv32_fetch.sv
module tb_rv32_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        branch_in;
  logic [31:0] branch_pc_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_in          (stall_in),
    .branch_in         (branch_in),
    .branch_pc_in      (branch_pc_in),
    .imem_req_valid_out(imem_req_valid_out),
    .imem_req_ready_in (imem_req_ready_in),
    .imem_addr_out     (imem_addr_out),
    .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in (imem_resp_data_in),
    .valid_out         (valid_out),
    .pc_out            (pc_out),
    .instr_out         (instr_out)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected request addresses and expected decode-side words
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  // Memory model state: accepts while budget > 0, answers lat cycles later
  int          budget = 0;
  int          lat    = 1;
  int          cnt    = 0;
  bit          pend   = 1'b0;
  logic [31:0] paddr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  // One clock: drive ready and observe the handshake at the falling edge,
  // then update the memory response just after the rising edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    imem_req_ready_in = (budget > 0);
    acc = rst_n && imem_req_valid_out && imem_req_ready_in;
    a   = imem_addr_out;
    if (acc) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_addr: unexpected request to %h", a);
      end else begin
        chk("req_addr", a, exp_addr_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    imem_resp_valid_in = 1'b0;
    if (acc) begin
      budget--;
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp_valid_in = 1'b1;
        imem_resp_data_in  = mem_word(paddr);
        pend               = 1'b0;
      end
    end
  endtask

  // Monitor: a word is new when valid_out is high and the previous slot
  // content was either empty or consumed (not stalled).
  initial begin
    logic pv;
    logic ps;
    pv = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        ps = 1'b0;
      end else begin
        if (valid_out && (!pv || !ps)) begin
          if (exp_pc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_word: unexpected pc %h instr %h", pc_out, instr_out);
          end else begin
            chk("out_pc", pc_out, exp_pc_q.pop_front());
            chk("out_instr", instr_out, exp_instr_q.pop_front());
          end
        end
        pv = valid_out;
        ps = stall_in;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat [8];
    pat = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

    rst_n              = 1'b0;
    stall_in           = 1'b0;
    branch_in          = 1'b0;
    branch_pc_in       = '0;
    imem_req_ready_in  = 1'b0;
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in  = '0;

    repeat (3) tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid_out), 32'd0);

    // Reset and sequential fetch
    rst_n = 1'b1;
    chk("idle_req_valid", 32'(imem_req_valid_out), 32'd0);
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0104);
    exp_addr_q.push_back(32'h0000_0108);
    expect_word(32'h0000_0100, 32'hC0DE_0100);
    expect_word(32'h0000_0104, 32'hC0DE_0104);
    expect_word(32'h0000_0108, 32'hC0DE_0108);
    budget = 3;
    lat    = 1;
    tick();
    chk("first_req_valid", 32'(imem_req_valid_out), 32'd1);
    chk("first_req_addr", imem_addr_out, 32'h0000_0100);
    chk("seq_valid_0", 32'(valid_out), pat[0]);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("seq_valid_%0d", i), 32'(valid_out), pat[i]);
    end

    // Stall with buffering
    exp_addr_q.push_back(32'h0000_010C);
    exp_addr_q.push_back(32'h0000_0110);
    expect_word(32'h0000_010C, 32'hC0DE_010C);
    expect_word(32'h0000_0110, 32'hC0DE_0110);
    budget = 2;
    tick();
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(valid_out), 32'd1);
      chk("stall_pc", pc_out, 32'h0000_010C);
      chk("stall_instr", instr_out, 32'hC0DE_010C);
      if (i >= 1) chk("hold_no_req", 32'(imem_req_valid_out), 32'd0);
    end
    stall_in = 1'b0;
    tick();
    chk("unstall_valid", 32'(valid_out), 32'd1);
    chk("unstall_pc", pc_out, 32'h0000_0110);
    tick();

    // Redirect during WAIT (response still pending)
    exp_addr_q.push_back(32'h0000_0114);
    budget = 1;
    lat    = 2;
    tick();
    branch_in    = 1'b1;
    branch_pc_in = 32'h0000_2002;
    tick();
    chk("redir_valid", 32'(valid_out), 32'd0);
    branch_in = 1'b0;
    lat       = 1;
    exp_addr_q.push_back(32'h0000_2000);
    expect_word(32'h0000_2000, 32'hC0DE_2000);
    budget = 1;
    repeat (3) tick();
    chk("redir_first_pc", pc_out, 32'h0000_2000);

    // Redirect coincident with a response, decode stalled
    stall_in = 1'b1;
    exp_addr_q.push_back(32'h0000_2004);
    budget = 1;
    tick();
    chk("coinc_pre_valid", 32'(valid_out), 32'd1);
    branch_in    = 1'b1;
    branch_pc_in = 32'h0000_3000;
    tick();
    chk("coinc_valid", 32'(valid_out), 32'd0);
    branch_in = 1'b0;
    stall_in  = 1'b0;
    exp_addr_q.push_back(32'h0000_3000);
    expect_word(32'h0000_3000, 32'hC0DE_3000);
    budget = 1;
    tick();
    tick();
    chk("coinc_next_pc", pc_out, 32'h0000_3000);

    // Wrap-around
    branch_in    = 1'b1;
    branch_pc_in = 32'hFFFF_FFFF;
    tick();
    branch_in = 1'b0;
    chk("wrap_addr", imem_addr_out, 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    expect_word(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    expect_word(32'h0000_0000, 32'hC0DE_0000);
    budget = 2;
    repeat (4) tick();

    // Async reset mid-WAIT
    stall_in = 1'b1;
    exp_addr_q.push_back(32'h0000_0004);
    budget = 1;
    lat    = 3;
    tick();
    chk("prereset_valid", 32'(valid_out), 32'd1);
    #2;
    rst_n              = 1'b0;
    pend               = 1'b0;
    imem_resp_valid_in = 1'b0;
    #1;
    chk("areset_valid", 32'(valid_out), 32'd0);
    chk("areset_pc", pc_out, 32'h0);
    chk("areset_instr", instr_out, 32'h0);
    chk("areset_req_valid", 32'(imem_req_valid_out), 32'd0);
    stall_in = 1'b0;
    budget   = 0;
    lat      = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rerst_idle", 32'(imem_req_valid_out), 32'd0);
    exp_addr_q.push_back(32'h0000_0100);
    expect_word(32'h0000_0100, 32'hC0DE_0100);
    budget = 1;
    tick();
    chk("rerst_req_valid", 32'(imem_req_valid_out), 32'd1);
    chk("rerst_addr", imem_addr_out, 32'h0000_0100);
    repeat (3) tick();

    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("word_q_drained", 32'(exp_pc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
